// File: rtl/cache_pkg.sv
// Shared definitions for the cache block-fill logic: block geometry,
// the fill FSM state type and a block-alignment helper.
package cache_pkg;

  // Block geometry: 8 words of 16 bits, 16 bytes per block.
  localparam int BLOCK_WORDS = 8;
  localparam int WORD_OFF_W  = 3;
  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_OFF_W = $clog2(BLOCK_BYTES);

  // Fill controller states.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fill_state_t;

  // Clear the byte offset so the address points at the start of its block.
  function automatic logic [15:0] blockAlign(input logic [15:0] addr);
    return {addr[15:BLOCK_OFF_W], {BLOCK_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dff.sv
// Plain W-bit register with synchronous active-low reset to zero.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture d every rising edge; reset wins.
  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/fill_cnt3.sv
// 3-bit word counter for a block fill. clr has priority over en.
// tc is high while the count sits at the last word of the block.
module fill_cnt3
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  output logic [WORD_OFF_W-1:0] cnt,
  output logic                  tc
);

  logic [WORD_OFF_W-1:0] cntNext;

  // Next count: clear, step, or hold. Stepping past the last word wraps to 0.
  always_comb begin
    cntNext = cnt;
    if (clr)     cntNext = '0;
    else if (en) cntNext = cnt + 1'b1;
  end

  dff #(.W(WORD_OFF_W)) cntReg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cntNext),
    .q     (cnt)
  );

  assign tc = (cnt == WORD_OFF_W'(BLOCK_WORDS - 1));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache block-fill controller. On a miss it latches the block address,
// issues one memory read per word of the block on consecutive cycles, and
// writes each returned word into the data array as it arrives. Requests and
// responses are counted separately, so any memory latency of one cycle or
// more is tolerated. The tag is written together with the last data word.
//
// Memory interface: mem_rd_en is a one-cycle request with no back-pressure;
// memory_data_valid marks one returned word per cycle, in request order.
//
// Optional build macro CACHE_FILL_MISS_CNT_EN adds a saturating 16-bit
// count of started fills on output miss_count.
module cache_fill_fsm
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_detected,
  input  logic [15:0]           miss_address,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data,
  output logic                  fsm_busy,
  output logic                  mem_rd_en,
  output logic [15:0]           memory_address,
  output logic                  write_data_array,
  output logic [WORD_OFF_W-1:0] fill_word_offset,
  output logic [15:0]           fill_data,
  output logic                  write_tag_array,
  output logic [15:0]           fill_block_addr
`ifdef CACHE_FILL_MISS_CNT_EN
  ,
  output logic [15:0]           miss_count
`endif
);

  fill_state_t           state;
  fill_state_t           stateNext;
  logic [15:0]           blockAddr;
  logic                  reqDone;

  logic [WORD_OFF_W-1:0] reqCnt;
  logic [WORD_OFF_W-1:0] rspCnt;
  logic                  reqTc;
  logic                  rspTc;

  logic                  startFill;
  logic                  reqEn;
  logic                  rspEn;
  logic                  lastWrite;

  // Request counter: word index of the next memory read.
  fill_cnt3 reqCounter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (startFill),
    .en    (reqEn),
    .cnt   (reqCnt),
    .tc    (reqTc)
  );

  // Response counter: word index of the next data-array write.
  fill_cnt3 rspCounter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (startFill),
    .en    (rspEn),
    .cnt   (rspCnt),
    .tc    (rspTc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Latch the block address at fill start; remember once all reads are issued
  // (the request counter wraps back to 0, so a separate flag is needed).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blockAddr <= '0;
      reqDone   <= 1'b0;
    end else if (startFill) begin
      blockAddr <= blockAlign(miss_address);
      reqDone   <= 1'b0;
    end else if (reqEn && reqTc) begin
      reqDone   <= 1'b1;
    end
  end

  // Next-state logic and outputs. Every output is forced low while rst_n is
  // low, because the registered state only clears at the reset edge.
  always_comb begin
    stateNext        = state;
    startFill        = 1'b0;
    reqEn            = 1'b0;
    rspEn            = 1'b0;
    lastWrite        = 1'b0;
    fsm_busy         = 1'b0;
    mem_rd_en        = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word_offset = '0;
    write_tag_array  = 1'b0;
    fill_block_addr  = '0;

    case (state)
      IDLE: begin
        // Returned words arriving here are stale and ignored.
        if (miss_detected) begin
          startFill = 1'b1;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        // New misses are ignored until this fill completes.
        reqEn     = !reqDone;
        rspEn     = memory_data_valid;
        lastWrite = rspEn && rspTc;
        if (lastWrite) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    fsm_busy  = rst_n && ((state == WAIT) || ((state == IDLE) && miss_detected));
    mem_rd_en = rst_n && reqEn;
    if (mem_rd_en) begin
      // Word address inside the block; never carries past the block offset.
      memory_address = {blockAddr[15:BLOCK_OFF_W], reqCnt, 1'b0};
    end
    write_data_array = rst_n && rspEn;
    if (write_data_array) fill_word_offset = rspCnt;
    write_tag_array  = rst_n && lastWrite;
    if (rst_n) fill_block_addr = blockAddr;
  end

  assign fill_data = memory_data;

`ifdef CACHE_FILL_MISS_CNT_EN
  logic [15:0] missCount;

  // Count started fills, sticking at the maximum value.
  always_ff @(posedge clk) begin
    if (!rst_n)                                  missCount <= '0;
    else if (startFill && (missCount != 16'hFFFF)) missCount <= missCount + 16'd1;
  end

  assign miss_count = rst_n ? missCount : 16'h0000;
`endif

endmodule
